prog_clk_divider: RTL and testbench
===================================

# prog_clk_divider

Multi-channel, runtime-programmable clock divider for the calculator datapath and display logic. It generates NUM_CH independent divided clocks from one system clock, each with its own half-period register that software-facing logic reloads through a write handshake. New divisors take effect only at a channel's half-period boundary, so outputs never glitch. Each channel also emits an optional single-cycle tick strobe for use as a clock enable.

## Interface
- NUM_CH, default 4: number of independent channels (1..16).
- DIV_W, default 27: width of the half-period value.
- DEFAULT_DIV, default 50_000_000: half-period loaded into every channel at reset.
- clk_in  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  NUM_CH  per-channel run enable.
- div_wr  input  1  divisor write strobe, single cycle.
- div_ch  input  $clog2(NUM_CH) (min 1)  target channel of the write.
- div_val  input  DIV_W  new half-period value.
- div_ready  output  1  high when the channel selected by div_ch can accept a write.
- clk_out  output  NUM_CH  divided clocks.
- tick  output  NUM_CH  one-cycle strobe on each clk_out rising edge.

## Operation
- Per channel: half-period register hp, counter cnt (DIV_W bits), staged value stg, pending flag pnd.
- Effective half-period is max(hp,1); hp = 0 behaves as 1.
- Enabled channel: cnt increments each cycle. At cnt == eff-1: cnt <= 0 and clk_out toggles. Output period = 2*eff cycles, 50 % duty.
- tick[i] is 1 in the same cycle clk_out[i] becomes 1, otherwise 0.
- Disabled channel: cnt <= 0, clk_out <= 0, tick <= 0. On re-enable, counting restarts from 0; the first rise occurs eff cycles after en goes high.
- Write accepted when div_wr && div_ready && div_ch < NUM_CH: stg <= div_val, pnd <= 1. Writes are ignored when not accepted: no state change and no error flag.
- div_ready = ~pnd[div_ch] (combinational). It is 0 for div_ch >= NUM_CH.
- Commit, enabled channel: at the first terminal count strictly after the acceptance cycle, hp <= stg and pnd <= 0. The toggle at that terminal count still uses the old hp; the next half-period uses the new value.
- Commit, disabled channel: hp <= stg and pnd <= 0 in the cycle after acceptance.
- Channels are fully independent. A write to one channel never disturbs another.

## Timing
- Reset (async assert, sync-to-clock release): cnt = 0, clk_out = 0, tick = 0, hp = DEFAULT_DIV, pnd = 0, div_ready = 1.
- Reset asserted mid-operation clears all pending writes. Staged values are lost.
- Outputs clk_out and tick are registered, with no combinational path from inputs. div_ready is combinational from div_ch and pnd.
- Write-to-effect latency, enabled channel: up to eff_old cycles until commit. The new half-period starts on the following cycle.
- A write in the same cycle as a terminal count commits at the next terminal count, not the current one.
- en deasserted while pnd = 1: the commit happens on the next cycle under the disabled rule.

## Configuration
- PROG_CLK_DIVIDER_TICK_EN defined: tick logic is built as described.
- Not defined: tick ports remain and are tied to 0, and no tick flops are synthesised. clk_out behaviour is unchanged.

## Structure
- Package prog_clk_div_pkg holds:
  - the DIV_W default constant,
  - the div_t typedef (logic [DIV_W-1:0]),
  - the channel index width function.
- Sub-module clk_div_channel holds one channel (hp, cnt, stg, pnd, clk_out, tick). The top level contains a generate loop over NUM_CH plus write decode and the div_ready mux.

## Test plan
- Reset with DEFAULT_DIV=3, en=4'hF -> all clk_out rise at cycle 3, period 6, tick high in cycles 3, 9, 15.
- Channel 1 at hp=3, write div_val=5 at cnt=1 -> div_ready(ch1) low until commit; toggle at cnt=2 uses 3, then half-periods are 5.
- Second write to channel 1 while pending (div_val=7) -> ignored; the committed value is 5.
- Write div_val=0 to channel 2, then enable -> clk_out[2] toggles every cycle, tick every 2 cycles.
- Channel 0 disabled, write div_val=4 -> commit next cycle; enable -> first rise after 4 cycles.
- Assert reset mid-period with a write pending -> all outputs 0 immediately, hp = DEFAULT_DIV, div_ready = 1.

Source files
------------

// File: rtl/prog_clk_div_pkg.sv
// Shared constants, types and helpers for the programmable clock divider.
// Optional build macro: PROG_CLK_DIVIDER_TICK_EN (enables tick strobe flops).
package prog_clk_div_pkg;

   localparam int DIV_W_DEFAULT = 27;

   typedef logic [DIV_W_DEFAULT-1:0] div_t;

   // Channel select width; a single channel still gets a 1-bit select.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Divisor write bus: master drives strobe/channel/value, slave reports readiness.
interface prog_clk_divider_if
   import prog_clk_div_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = DIV_W_DEFAULT
);
   localparam int CH_W = ch_idx_w(NUM_CH);

   logic             div_wr;
   logic [CH_W-1:0]  div_ch;
   logic [DIV_W-1:0] div_val;
   logic             div_ready;

   modport master (output div_wr, output div_ch, output div_val, input div_ready);
   modport slave  (input div_wr, input div_ch, input div_val, output div_ready);

endinterface

// File: rtl/prog_clk_divider_channel.sv
// One divider channel: half-period register, counter, staged divisor and pending flag.
// Tick flop exists only when PROG_CLK_DIVIDER_TICK_EN is defined.
module clk_div_channel #(
   parameter int               DIV_W      = 27,
   parameter logic [DIV_W-1:0] DEFAULT_HP = '1
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             en,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_val,
   output logic             pnd,
   output logic             clk_out,
   output logic             tick
);
   logic [DIV_W-1:0] hp_reg;
   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] stg_reg;
   logic             pnd_reg;
   logic             clk_reg;
   logic [DIV_W-1:0] eff;
   logic             term;

   // A zero half-period behaves exactly like one.
   assign eff  = (hp_reg == '0) ? DIV_W'(1) : hp_reg;
   assign term = en && (cnt_reg == eff - DIV_W'(1));

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         hp_reg  <= DEFAULT_HP;
         cnt_reg <= '0;
         stg_reg <= '0;
         pnd_reg <= 1'b0;
         clk_reg <= 1'b0;
      end else begin
         if (!en) begin
            cnt_reg <= '0;
            clk_reg <= 1'b0;
            if (pnd_reg) begin
               hp_reg  <= stg_reg;
               pnd_reg <= 1'b0;
            end
         end else if (term) begin
            // Toggle with the old half-period; the new one governs the next phase.
            cnt_reg <= '0;
            clk_reg <= ~clk_reg;
            if (pnd_reg) begin
               hp_reg  <= stg_reg;
               pnd_reg <= 1'b0;
            end
         end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
         end
         // Accept only arrives with pnd_reg low, so it never collides with a commit.
         if (wr) begin
            stg_reg <= wr_val;
            pnd_reg <= 1'b1;
         end
      end
   end

`ifdef PROG_CLK_DIVIDER_TICK_EN
   logic tick_reg;
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         tick_reg <= 1'b0;
      end else begin
         tick_reg <= term && !clk_reg;
      end
   end
   assign tick = tick_reg;
`else
   assign tick = 1'b0;
`endif

   assign pnd     = pnd_reg;
   assign clk_out = clk_reg;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: write decode, ready mux and channel array.
// PROG_CLK_DIVIDER_TICK_EN builds the per-channel tick strobes; otherwise tick is 0.
module prog_clk_divider
   import prog_clk_div_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = DIV_W_DEFAULT,
   parameter int DEFAULT_DIV = 50_000_000
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    en,
   prog_clk_divider_if.slave    div_bus,
   output logic [NUM_CH-1:0]    clk_out,
   output logic [NUM_CH-1:0]    tick
);
   localparam int               CH_W       = ch_idx_w(NUM_CH);
   localparam int               PAD_W      = 1 << CH_W;
   localparam logic [DIV_W-1:0] DEFAULT_HP = DIV_W'(DEFAULT_DIV);

   logic [NUM_CH-1:0] pnd;
   logic [PAD_W-1:0]  pnd_pad;
   logic              ch_valid;
   logic              ready;

   // Unused select codes read as pending-free but are masked by ch_valid.
   assign pnd_pad  = PAD_W'(pnd);
   assign ch_valid = (int'(div_bus.div_ch) < NUM_CH);
   assign ready    = ch_valid && !pnd_pad[div_bus.div_ch];

   assign div_bus.div_ready = ready;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic wr_sel;
         assign wr_sel = div_bus.div_wr && ready && (div_bus.div_ch == CH_W'(gi));

         clk_div_channel #(
            .DIV_W      (DIV_W),
            .DEFAULT_HP (DEFAULT_HP)
         ) u_ch (
            .clk_in  (clk_in),
            .reset   (reset),
            .en      (en[gi]),
            .wr      (wr_sel),
            .wr_val  (div_bus.div_val),
            .pnd     (pnd[gi]),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: timestamp-based model plus directed literal checks.
module tb_prog_clk_divider;
   import prog_clk_div_pkg::*;

   localparam int NUM_CH      = 4;
   localparam int DIV_W       = DIV_W_DEFAULT;
   localparam int DEFAULT_DIV = 3;
`ifdef PROG_CLK_DIVIDER_TICK_EN
   localparam bit TICK_ON = 1'b1;
`else
   localparam bit TICK_ON = 1'b0;
`endif

   logic              clk_in = 1'b0;
   logic              reset  = 1'b0;
   logic [NUM_CH-1:0] en     = '0;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;

   prog_clk_divider_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

   prog_clk_divider #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (en),
      .div_bus (bus),
      .clk_out (clk_out),
      .tick    (tick)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int base     = 0;
   bit checking = 1'b0;

   always @(posedge clk_in) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - base);
      end
   endtask

   // Model: each channel remembers when its current half-period started and
   // toggles once exactly eff cycles have elapsed since then.
   int                hp_m   [NUM_CH];
   int                stg_m  [NUM_CH];
   int                last_m [NUM_CH];
   bit                pend_m [NUM_CH];
   logic [NUM_CH-1:0] lvl_m  = '0;
   logic [NUM_CH-1:0] tick_m = '0;
   int                t_m    = 0;

   always @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            hp_m[i]   = DEFAULT_DIV;
            stg_m[i]  = 0;
            pend_m[i] = 1'b0;
            last_m[i] = t_m;
         end
         lvl_m  = '0;
         tick_m = '0;
      end else begin
         int ch;
         bit acc;
         int eff;
         ch  = int'(bus.div_ch);
         acc = bus.div_wr && (ch < NUM_CH) && !pend_m[ch];
         t_m++;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!en[i]) begin
               lvl_m[i]  = 1'b0;
               tick_m[i] = 1'b0;
               last_m[i] = t_m;
               if (pend_m[i]) begin
                  hp_m[i]   = stg_m[i];
                  pend_m[i] = 1'b0;
               end
            end else begin
               eff = (hp_m[i] == 0) ? 1 : hp_m[i];
               if (t_m - last_m[i] == eff) begin
                  lvl_m[i]  = ~lvl_m[i];
                  tick_m[i] = lvl_m[i] & TICK_ON;
                  last_m[i] = t_m;
                  if (pend_m[i]) begin
                     hp_m[i]   = stg_m[i];
                     pend_m[i] = 1'b0;
                  end
               end else begin
                  tick_m[i] = 1'b0;
               end
            end
         end
         if (acc) begin
            stg_m[ch]  = int'(bus.div_val);
            pend_m[ch] = 1'b1;
         end
      end
   end

   always @(negedge clk_in) begin
      if (checking) begin
         check("clk_out", 32'(clk_out), 32'(lvl_m));
         check("tick", 32'(tick), 32'(tick_m));
         check("div_ready", 32'(bus.div_ready),
               32'((int'(bus.div_ch) < NUM_CH) && !pend_m[bus.div_ch]));
      end
   end

   task automatic run_to(input int n);
      while (cyc - base < n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   function automatic logic [31:0] tick_exp(input logic [NUM_CH-1:0] mask);
      return TICK_ON ? 32'(mask) : 32'd0;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      div_t val;
      bus.div_wr  = 1'b0;
      bus.div_ch  = '0;
      bus.div_val = '0;
      repeat (3) @(posedge clk_in);
      #1;
      checking = 1'b1;
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_ready", 32'(bus.div_ready), 32'd1);

      // All channels at the reset half-period of 3.
      reset = 1'b1;
      en    = 4'hF;
      base  = cyc;
      run_to(2);  check("hp3_pre_rise", 32'(clk_out), 32'h0);
      run_to(3);  check("hp3_rise3", 32'(clk_out), 32'hF);
                  check("hp3_tick3", 32'(tick), tick_exp(4'hF));
      run_to(4);  check("hp3_tick4", 32'(tick), 32'h0);
      run_to(6);  check("hp3_fall6", 32'(clk_out), 32'h0);
      run_to(9);  check("hp3_tick9", 32'(tick), tick_exp(4'hF));
      run_to(15); check("hp3_tick15", 32'(tick), tick_exp(4'hF));

      // Channel 1: write 5 at cnt=1, then a second write of 7 while pending.
      run_to(16);
      val = 5;
      bus.div_ch  = 2'd1;
      bus.div_val = val;
      bus.div_wr  = 1'b1;
      #1 check("ch1_ready_before", 32'(bus.div_ready), 32'd1);
      run_to(17);
      check("ch1_ready_pending", 32'(bus.div_ready), 32'd0);
      val = 7;
      bus.div_val = val;
      run_to(18);
      bus.div_wr = 1'b0;
      #1 check("ch1_ready_committed", 32'(bus.div_ready), 32'd1);
      check("ch1_fall18", 32'(clk_out[1]), 32'd0);
      run_to(22); check("ch1_edge22", 32'(clk_out), 32'hD);
      run_to(23); check("ch1_edge23", 32'(clk_out), 32'hF);
      run_to(28); check("ch1_fall28", 32'(clk_out[1]), 32'd0);

      // Channel 2: disable, write 0, re-enable -> toggles every cycle.
      en          = 4'b1011;
      bus.div_ch  = 2'd2;
      bus.div_val = '0;
      bus.div_wr  = 1'b1;
      run_to(29);
      bus.div_wr = 1'b0;
      run_to(30);
      en = 4'hF;
      run_to(31); check("ch2_rise31", 32'(clk_out[2]), 32'd1);
                  check("ch2_tick31", 32'(tick[2]), tick_exp(4'h1));
      run_to(32); check("ch2_fall32", 32'(clk_out[2]), 32'd0);
                  check("ch2_tick32", 32'(tick[2]), 32'd0);
      run_to(33); check("ch2_rise33", 32'(clk_out[2]), 32'd1);

      // Channel 0: disabled write of 4 commits next cycle, first rise 4 cycles after enable.
      run_to(34);
      en          = 4'b1110;
      val         = 4;
      bus.div_ch  = 2'd0;
      bus.div_val = val;
      bus.div_wr  = 1'b1;
      run_to(35);
      bus.div_wr = 1'b0;
      #1 check("ch0_ready_pending", 32'(bus.div_ready), 32'd0);
      run_to(36); check("ch0_ready_commit", 32'(bus.div_ready), 32'd1);
      run_to(37);
      en = 4'hF;
      run_to(40); check("ch0_edge40", 32'(clk_out[0]), 32'd0);
      run_to(41); check("ch0_rise41", 32'(clk_out[0]), 32'd1);

      // Reset mid-period with a pending write on channel 3.
      run_to(43);
      val         = 9;
      bus.div_ch  = 2'd3;
      bus.div_val = val;
      bus.div_wr  = 1'b1;
      run_to(44);
      bus.div_wr = 1'b0;
      #1 check("ch3_ready_pending", 32'(bus.div_ready), 32'd0);
      #1 reset = 1'b0;
      #1 check("async_rst_clk_out", 32'(clk_out), 32'd0);
      check("async_rst_tick", 32'(tick), 32'd0);
      check("async_rst_ready", 32'(bus.div_ready), 32'd1);
      repeat (2) @(posedge clk_in);
      #1;
      reset = 1'b1;
      base  = cyc;
      run_to(3); check("post_rst_rise3", 32'(clk_out), 32'hF);
      run_to(6); check("post_rst_fall6", 32'(clk_out), 32'h0);
      run_to(9); check("post_rst_rise9", 32'(clk_out), 32'hF);
      run_to(10);

      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
